// File: rtl/alu_cmd_pkg.sv
// -----------------------------------------------------------------------------
// alu_cmd_pkg
// Shared types and constants for the ALU command engine: ALU opcodes, the
// frame-assembly FSM states, command-header bit positions and flag indices.
// -----------------------------------------------------------------------------
package alu_cmd_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        GET_A,
        GET_B,
        EXEC
    } state_e;

    // Header byte layout (bit 4 is ignored).
    localparam int HDR_OP_MSB = 7;
    localparam int HDR_OP_LSB = 6;
    localparam int HDR_PWM_WR = 5;
    localparam int HDR_CH_MSB = 3;
    localparam int HDR_CH_LSB = 0;

    // Bit positions inside the 4-bit flags output {V,C,N,Z}.
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_cmd_engine_pwm_bank.sv
// -----------------------------------------------------------------------------
// pwm_bank
// NCH glitch-free PWM channels sharing one WIDTH-bit counter that advances
// once every PRESC clocks. New duties are written into a pending register and
// copied to the active register only when the counter wraps to 0, so a
// period is never cut short.
//
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   wr_en       write wr_duty into pending duty of channel wr_ch
//   wr_ch       channel index (values >= NCH are ignored)
//   wr_duty     new duty, high steps per 2^WIDTH-step period
//   pwm_out     registered PWM outputs, one per channel
// -----------------------------------------------------------------------------
module pwm_bank #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int PRESC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [3:0]       wr_ch,
    input  logic [WIDTH-1:0] wr_duty,
    output logic [NCH-1:0]   pwm_out
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

    logic [PW-1:0]    presc_cnt;
    logic             step;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] pending_duty [NCH];
    logic [WIDTH-1:0] active_duty  [NCH];

    assign step = (presc_cnt == PW'(PRESC - 1));

    // NOTE: sequential state is always assigned with <=, so every register
    // samples the pre-edge value of its neighbours regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_cnt <= '0;
            cnt       <= '0;
        end else begin
            presc_cnt <= step ? '0 : presc_cnt + PW'(1);
            if (step) begin
                cnt <= cnt + WIDTH'(1);
            end
        end
    end

    // NOTE: the duty arrays are small register files that drive outputs
    // directly, so they are reset like any other flop rather than left as
    // uninitialised memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                pending_duty[i] <= '0;
                active_duty[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_en && (wr_ch == 4'(i))) begin
                    pending_duty[i] <= wr_duty;
                end
                // Hand-over on the wrap step; a write landing on that same
                // clock is forwarded so it is not delayed a whole period.
                if (step && (cnt == '1)) begin
                    active_duty[i] <= (wr_en && (wr_ch == 4'(i))) ? wr_duty
                                                                  : pending_duty[i];
                end
            end
        end
    end

    // Outputs are registered so the comparator cannot glitch onto the pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                pwm_out[i] <= (cnt < active_duty[i]);
            end
        end
    end

endmodule

// File: rtl/alu_cmd_engine.sv
// -----------------------------------------------------------------------------
// alu_cmd_engine
// Assembles byte-serial command frames (header, A, B; operands little-endian,
// WIDTH/8 bytes each) into an ALU operation, publishes the result with
// {V,C,N,Z} flags and optionally loads it as the duty of one PWM channel.
//
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   rx_valid    one-cycle strobe qualifying rx_data
//   rx_data     received byte
//   busy        frame in progress
//   res, flags  last result and its {V,C,N,Z} flags, held
//   res_valid   one-cycle pulse when res/flags update
//   err         one-cycle pulse: bad PWM channel or inter-byte timeout
//   pwm_out     NCH PWM outputs
//
// Build option: define ALU_CMD_TIMEOUT_EN to abort a partial frame after
// TIMEOUT clocks without a byte. Undefined, a partial frame waits forever.
// -----------------------------------------------------------------------------
module alu_cmd_engine
    import alu_cmd_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NCH     = 4,
    parameter int PRESC   = 1,
    parameter int TIMEOUT = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             busy,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       flags,
    output logic             res_valid,
    output logic             err,
    output logic [NCH-1:0]   pwm_out
);

    localparam int NB = WIDTH / 8;

    if ((WIDTH % 8) != 0 || WIDTH < 8 || WIDTH > 32 || NCH < 1 || NCH > 16 ||
        PRESC < 1 || TIMEOUT < 2) begin : g_param_check
        $error("alu_cmd_engine: parameter out of range");
    end

    state_e           state, state_nxt;
    op_e              op_q;
    logic             pwm_wr_q;
    logic [3:0]       ch_q;
    logic [WIDTH-1:0] a_q, b_q, b_full;
    logic [2:0]       byte_cnt;
    logic             in_get, last_byte, hdr_take, frame_done;
    logic             ch_bad, timeout_hit, pwm_wr_en;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] y;
    logic [3:0]       y_flags;

    // Little-endian assembly: each byte enters at the top and the word
    // shifts down, so after NB bytes the first one sits in bits [7:0].
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                  input logic [7:0]       b);
        logic [WIDTH-1:0] t;
        t = cur >> 8;
        t[WIDTH-1 -: 8] = b;
        return t;
    endfunction

    assign in_get     = (state == GET_A) || (state == GET_B);
    assign last_byte  = (byte_cnt == 3'(NB - 1));
    assign hdr_take   = rx_valid && ((state == IDLE) || (state == EXEC));
    assign frame_done = rx_valid && last_byte && (state == GET_B);
    assign ch_bad     = (int'(ch_q) >= NCH);
    assign busy       = (state != IDLE);
    // B including the byte arriving now, so the result is ready for EXEC.
    assign b_full     = shift_in(b_q, rx_data);
    assign pwm_wr_en  = (state == EXEC) && pwm_wr_q && !ch_bad;

`ifdef ALU_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    // A byte on the expiring clock wins because timeout_hit needs !rx_valid.
    assign timeout_hit = in_get && !rx_valid && (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (in_get && !rx_valid && !timeout_hit) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rx_valid) state_nxt = GET_A;
            GET_A:   if (rx_valid && last_byte) state_nxt = GET_B;
                     else if (timeout_hit)      state_nxt = IDLE;
            GET_B:   if (rx_valid && last_byte) state_nxt = EXEC;
                     else if (timeout_hit)      state_nxt = IDLE;
            EXEC:    state_nxt = rx_valid ? GET_A : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= OP_ADD;
            pwm_wr_q <= 1'b0;
            ch_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            byte_cnt <= '0;
        end else if (hdr_take) begin
            op_q     <= op_e'(rx_data[HDR_OP_MSB:HDR_OP_LSB]);
            pwm_wr_q <= rx_data[HDR_PWM_WR];
            ch_q     <= rx_data[HDR_CH_MSB:HDR_CH_LSB];
            byte_cnt <= '0;
        end else if (rx_valid && in_get) begin
            byte_cnt <= last_byte ? '0 : byte_cnt + 3'd1;
            if (state == GET_A) begin
                a_q <= shift_in(a_q, rx_data);
            end else begin
                b_q <= b_full;
            end
        end
    end

    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_full};
        diff    = {1'b0, a_q} - {1'b0, b_full};
        y       = '0;
        y_flags = '0;
        case (op_q)
            OP_ADD: begin
                y               = sum[WIDTH-1:0];
                y_flags[FLAG_C] = sum[WIDTH];
                y_flags[FLAG_V] = (a_q[WIDTH-1] == b_full[WIDTH-1]) &&
                                  (y[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                y               = diff[WIDTH-1:0];
                y_flags[FLAG_C] = ~diff[WIDTH];   // carry means no borrow
                y_flags[FLAG_V] = (a_q[WIDTH-1] != b_full[WIDTH-1]) &&
                                  (y[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  y = a_q & b_full;
            default: y = a_q | b_full;
        endcase
        y_flags[FLAG_Z] = (y == '0);
        y_flags[FLAG_N] = y[WIDTH-1];
    end

    // Result registers load on the edge that captures the last B byte, so
    // res, flags, res_valid and a bad-channel err are all visible in EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res       <= '0;
            flags     <= '0;
            res_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            res_valid <= frame_done;
            err       <= (frame_done && pwm_wr_q && ch_bad) || timeout_hit;
            if (frame_done) begin
                res   <= y;
                flags <= y_flags;
            end
        end
    end

    pwm_bank #(
        .WIDTH (WIDTH),
        .NCH   (NCH),
        .PRESC (PRESC)
    ) u_pwm_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (pwm_wr_en),
        .wr_ch   (ch_q),
        .wr_duty (res),
        .pwm_out (pwm_out)
    );

endmodule

// File: tb/tb_alu_cmd_engine.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_engine
// Self-checking bench for alu_cmd_engine (WIDTH=8, NCH=4, PRESC=1,
// TIMEOUT=20). Expected results come from an arithmetic reference model and
// a per-channel duty array; PWM behaviour is checked by counting high clocks
// over whole periods.
// -----------------------------------------------------------------------------
module tb_alu_cmd_engine;

    localparam int WIDTH   = 8;
    localparam int NCH     = 4;
    localparam int PRESC   = 1;
    localparam int TIMEOUT = 20;
    localparam int NB      = WIDTH / 8;
    localparam int PERIOD  = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rx_valid = 1'b0;
    logic [7:0]       rx_data = 8'h00;
    logic             busy;
    logic [WIDTH-1:0] res;
    logic [3:0]       flags;
    logic             res_valid;
    logic             err;
    logic [NCH-1:0]   pwm_out;

    alu_cmd_engine #(
        .WIDTH   (WIDTH),
        .NCH     (NCH),
        .PRESC   (PRESC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .busy      (busy),
        .res       (res),
        .flags     (flags),
        .res_valid (res_valid),
        .err       (err),
        .pwm_out   (pwm_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic             err;
        logic [3:0]       flags;
        logic [WIDTH-1:0] res;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   duty_model [NCH];
    bit   tmo_window = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: signed/unsigned arithmetic straight from the op rules.
    function automatic void model_frame(input logic [7:0] hdr, input int a, input int b);
        int   sa, sb, r, y, ch;
        bit   c, v, bad;
        exp_t e;
        sa = (a >= PERIOD / 2) ? a - PERIOD : a;
        sb = (b >= PERIOD / 2) ? b - PERIOD : b;
        c = 1'b0;
        v = 1'b0;
        case (hdr[7:6])
            2'd0: begin
                r = a + b;
                y = r % PERIOD;
                c = (r >= PERIOD);
                v = (sa + sb > PERIOD / 2 - 1) || (sa + sb < -(PERIOD / 2));
            end
            2'd1: begin
                y = (a - b + PERIOD) % PERIOD;
                c = (a >= b);
                v = (sa - sb > PERIOD / 2 - 1) || (sa - sb < -(PERIOD / 2));
            end
            2'd2:    y = a & b;
            default: y = a | b;
        endcase
        ch  = int'(hdr[3:0]);
        bad = hdr[5] && (ch >= NCH);
        if (hdr[5] && !bad) duty_model[ch] = y;
        e.res   = WIDTH'(y);
        e.flags = {v, c, (y >= PERIOD / 2), (y == 0)};
        e.err   = bad;
        exp_q.push_back(e);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    // Leaves rx_valid high on the last byte so a caller can stream the next
    // header straight into the EXEC cycle.
    task automatic send_frame(input logic [7:0] hdr, input logic [WIDTH-1:0] a,
                              input logic [WIDTH-1:0] b, input int gap);
        logic [WIDTH-1:0] t;
        send_byte(hdr);
        t = a;
        for (int i = 0; i < NB; i++) begin
            idle(gap);
            send_byte(t[7:0]);
            t = t >> 8;
        end
        t = b;
        for (int i = 0; i < NB; i++) begin
            idle(gap);
            send_byte(t[7:0]);
            t = t >> 8;
        end
    endtask

    // Any PERIOD consecutive clocks of a settled channel hold exactly duty highs.
    task automatic measure_all(input string tag);
        int highs [NCH];
        repeat (PERIOD + 50) @(negedge clk);
        foreach (highs[i]) highs[i] = 0;
        repeat (PERIOD) begin
            @(negedge clk);
            for (int i = 0; i < NCH; i++) if (pwm_out[i]) highs[i]++;
        end
        for (int i = 0; i < NCH; i++) check($sformatf("%s_ch%0d", tag, i), highs[i], duty_model[i]);
    endtask

    // Result monitor: every res_valid pulse must match the next queued frame.
    initial begin
        forever begin
            @(negedge clk);
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_res_valid", res_valid, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("res", res, mon_e.res);
                    check("flags", flags, mon_e.flags);
                    check("err_with_res", err, mon_e.err);
                    check("busy_in_exec", busy, 1'b1);
                end
            end else if (err && !tmo_window) begin
                check("spurious_err", err, 1'b0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] hdr;
        int         a, b, gap, post, h1, h2;
        bit         found, prev;

        foreach (duty_model[i]) duty_model[i] = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_res", res, 0);
        check("rst_flags", flags, 0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_pwm", pwm_out, 0);
        rst = 1'b0;
        idle(2);

        // ADD with PWM write to channel 0
        model_frame(8'h20, 8'h7F, 8'h01);
        send_frame(8'h20, 8'h7F, 8'h01, 0);
        idle(1);
        check("add_res_valid", res_valid, 1'b1);
        idle(1);
        check("add_busy_fall", busy, 1'b0);
        check("add_rv_single", res_valid, 1'b0);
        check("add_res_held", res, 8'h80);
        check("add_flags_held", flags, 4'b1010);
        measure_all("add_pwm");

        // SUB without PWM write
        model_frame(8'h41, 8'h05, 8'h05);
        send_frame(8'h41, 8'h05, 8'h05, 1);
        idle(1);
        check("sub_flags", flags, 4'b0101);
        measure_all("sub_pwm");

        // Bad channel: AND, pwm_wr, channel 5
        model_frame(8'hA5, 8'hF0, 8'h3C);
        send_frame(8'hA5, 8'hF0, 8'h3C, 0);
        idle(1);
        check("badch_err", err, 1'b1);
        check("badch_res", res, 8'h30);
        idle(1);
        check("badch_err_single", err, 1'b0);
        measure_all("badch_pwm");

        // Partial frame: header + A, then silence
        send_byte(8'h20);
        send_byte(8'h10);
        idle(1);
`ifdef ALU_CMD_TIMEOUT_EN
        tmo_window = 1'b1;
        for (int i = 1; i <= TIMEOUT; i++) begin
            idle(1);
            check($sformatf("tmo_err_clk%0d", i), err, (i == TIMEOUT));
        end
        check("tmo_busy_low", busy, 1'b0);
        tmo_window = 1'b0;
        idle(2);
        model_frame(8'h20, 8'h10, 8'h22);
        send_frame(8'h20, 8'h10, 8'h22, 0);
`else
        idle(3 * TIMEOUT);
        check("notmo_busy_held", busy, 1'b1);
        check("notmo_no_err", err, 1'b0);
        model_frame(8'h20, 8'h10, 8'h22);
        send_byte(8'h22);
`endif
        idle(1);
        check("after_partial_res", res, 8'h32);
        idle(2);

        // Duty change in the middle of a period on channel 2
        model_frame(8'h22, 8'h40, 8'h00);
        send_frame(8'h22, 8'h40, 8'h00, 0);
        idle(PERIOD + 50);
        found = 1'b0;
        prev  = pwm_out[2];
        for (int k = 0; k < 3 * PERIOD && !found; k++) begin
            @(negedge clk);
            if (!prev && pwm_out[2]) found = 1'b1;
            prev = pwm_out[2];
        end
        check("mid_edge_found", found, 1'b1);
        h1 = 1;
        h2 = 0;
        fork
            begin
                repeat (PERIOD - 1) begin
                    @(negedge clk);
                    if (pwm_out[2]) h1++;
                end
                repeat (PERIOD) begin
                    @(negedge clk);
                    if (pwm_out[2]) h2++;
                end
            end
            begin
                idle(100);
                model_frame(8'h22, 8'hC0, 8'h00);
                send_frame(8'h22, 8'hC0, 8'h00, 0);
                idle(1);
            end
        join
        check("mid_cur_period", h1, 64);
        check("mid_next_period", h2, 192);

        // Reset in the middle of a frame
        idle(2);
        send_byte(8'h20);
        send_byte(8'h01);
        idle(1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_pwm", pwm_out, 0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_res", res, 0);
        check("midrst_flags", flags, 0);
        check("midrst_res_valid", res_valid, 1'b0);
        check("midrst_err", err, 1'b0);
        foreach (duty_model[i]) duty_model[i] = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(2);
        model_frame(8'h20, 8'h02, 8'h03);
        send_frame(8'h20, 8'h02, 8'h03, 0);
        idle(1);
        check("postrst_res", res, 8'h05);
        idle(2);

        // Randomized frames, including back-to-back headers in EXEC
        for (int n = 0; n < 40; n++) begin
            hdr  = 8'($urandom);
            a    = $urandom_range(0, PERIOD - 1);
            b    = $urandom_range(0, PERIOD - 1);
            gap  = $urandom_range(0, 1);
            post = $urandom_range(0, 2);
            model_frame(hdr, a, b);
            send_frame(hdr, WIDTH'(a), WIDTH'(b), gap);
            idle(post);
        end
        idle(3);
        measure_all("rand_pwm");
        check("all_results_seen", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
